// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data wins by default; a streak counter forces a fetch grant to avoid starvation.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            starve;
    logic            gnt_i, gnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        starve    = (streak_q == STREAK_MAX);
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (mem_ready) begin
                        gnt_i = if_req && (!d_req || starve);
                        gnt_d = d_req && !gnt_i;
                    end
                    if (gnt_i) begin
                        if_gnt   = 1'b1;
                        mem_req  = 1'b1;
                        mem_addr = if_addr;
                        mem_be   = '1;
                        streak_d = '0;
                        state_d  = BUSY_I;
                    end else if (gnt_d) begin
                        d_gnt     = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        // loads always read the full word
                        mem_be    = d_we ? d_be : '1;
                        state_d   = BUSY_D;
                        if (if_req && !starve) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_rvalid) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                        state_d   = IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_rvalid) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks for mem_port_arbiter.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_be(d_be),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be(mem_be),
        .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        #1;
        n_cmp++;
        if ({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_hs: got %b want 00000",
                     {mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid});
        end
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        #1;
        n_cmp++;
        if ({if_rvalid, d_rvalid, mem_req} !== 3'b0) begin
            n_err++;
            $display("FAIL reset_stale: got %b want 000",
                     {if_rvalid, d_rvalid, mem_req});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
            n_err++;
            $display("FAIL idle_zero: got %h %h %h want 0",
                     mem_addr, mem_wdata, mem_be);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({if_gnt, d_gnt, mem_req, mem_we} !== 4'b1010) begin
            n_err++;
            $display("FAIL fetch_gnt: got %b want 1010",
                     {if_gnt, d_gnt, mem_req, mem_we});
        end
        n_cmp++;
        if (mem_addr !== 32'h100 || mem_be !== 4'hF || mem_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL fetch_bus: got %h %h %h want 100 f 0",
                     mem_addr, mem_be, mem_wdata);
        end
        @(negedge clk);
        if_addr = 32'h104; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        n_cmp++;
        if ({if_rvalid, d_rvalid, if_gnt, mem_req} !== 4'b1000) begin
            n_err++;
            $display("FAIL fetch_rv: got %b want 1000",
                     {if_rvalid, d_rvalid, if_gnt, mem_req});
        end
        n_cmp++;
        if (if_rdata !== 32'h0050_0093) begin
            n_err++;
            $display("FAIL fetch_rdata: got %h want 00500093", if_rdata);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h104 || if_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_next: got %b %h %b want 1 104 0",
                     if_gnt, mem_addr, if_rvalid);
        end
        @(negedge clk);
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin
            n_err++;
            $display("FAIL fetch_rv2: got %b %h want 1 13", if_rvalid, if_rdata);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_contention();
        int  dn;
        bit  exp_f;
        logic [31:0] exp_a;
        dn = 0;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h1; d_wdata = 32'h0;
        for (int n = 0; n < 11; n++) begin
            exp_f = (n == 4) || (n == 9);
            d_addr = 32'h200 + 32'(4 * dn);
            exp_a = exp_f ? 32'h300 : 32'h200 + 32'(4 * dn);
            #1;
            n_cmp++;
            if ({if_gnt, d_gnt} !== {exp_f, !exp_f} || mem_addr !== exp_a
                || mem_be !== 4'hF) begin
                n_err++;
                $display("FAIL contend_gnt[%0d]: got %b%b %h %h want %b%b %h f",
                         n, if_gnt, d_gnt, mem_addr, mem_be,
                         exp_f, !exp_f, exp_a);
            end
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = 32'(n);
            #1;
            n_cmp++;
            if ({if_rvalid, d_rvalid} !== {exp_f, !exp_f}) begin
                n_err++;
                $display("FAIL contend_rv[%0d]: got %b%b want %b%b",
                         n, if_rvalid, d_rvalid, exp_f, !exp_f);
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!exp_f) dn++;
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40;
        d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
        #1;
        n_cmp++;
        if ({d_gnt, if_gnt, mem_req, mem_we} !== 4'b1011 || mem_be !== 4'h3
            || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL store_gnt: got %b %h %h %h want 1011 3 deadbeef 40",
                     {d_gnt, if_gnt, mem_req, mem_we}, mem_be, mem_wdata, mem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            d_req = 1'b0;
            mem_rvalid = (k == 2);
            #1;
            n_cmp++;
            if ({d_rvalid, if_rvalid} !== {(k == 2), 1'b0}) begin
                n_err++;
                $display("FAIL store_rv[%0d]: got %b%b want %b0",
                         k, d_rvalid, if_rvalid, (k == 2));
            end
        end
        @(negedge clk);
        mem_rvalid = 1'b0; d_we = 1'b0;
        #1;
        n_cmp++;
        if (d_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL store_pulse: got %b want 0", d_rvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if ({d_gnt, if_gnt, mem_req} !== 3'b000) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: got %b want 000",
                         k, {d_gnt, if_gnt, mem_req});
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({d_gnt, mem_req} !== 2'b11 || mem_addr !== 32'h80) begin
            n_err++;
            $display("FAIL bp_gnt: got %b %h want 11 80", {d_gnt, mem_req}, mem_addr);
        end
        @(negedge clk);
        d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL bp_rv: got %b %h want 1 cafe0001", d_rvalid, d_rdata);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_stale: got %b want 00", {if_rvalid, d_rvalid});
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit exp_f;
        if_req = 1'b1; if_addr = 32'h500; d_req = 1'b0;
        #1;
        n_cmp++;
        if (if_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_gnt: got %b want 1", if_gnt);
        end
        @(negedge clk);
        if_req = 1'b0; rst = 1'b1; mem_rvalid = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL rmid_rst: got %b want 00000",
                     {mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL rmid_stale: got %b want 00", {if_rvalid, d_rvalid});
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        // Build a streak of 3, then reset; a cleared streak needs 4 more data wins.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        for (int n = 0; n < 3; n++) begin
            #1;
            n_cmp++;
            if (d_gnt !== 1'b1) begin
                n_err++;
                $display("FAIL rmid_pre[%0d]: got %b want 1", n, d_gnt);
            end
            @(negedge clk);
            mem_rvalid = 1'b1;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            exp_f = (n == 4);
            #1;
            n_cmp++;
            if ({if_gnt, d_gnt} !== {exp_f, !exp_f}) begin
                n_err++;
                $display("FAIL rmid_streak[%0d]: got %b%b want %b%b",
                         n, if_gnt, d_gnt, exp_f, !exp_f);
            end
            @(negedge clk);
            mem_rvalid = 1'b1;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_random();
        int txn, cyc, lat, cnt, wait_d, m_streak;
        bit busy, own_f, if_p, d_p, eg_i, eg_d;
        logic [31:0] exp_a;
        logic [3:0]  exp_be;
        txn = 0; cyc = 0; lat = 1; cnt = 0; wait_d = 0; m_streak = 0;
        busy = 0; own_f = 0; if_p = 0; d_p = 0;
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        while (txn < 1000 && cyc < 20000) begin
            if (!if_p && $urandom_range(0, 2) != 0) begin
                if_p = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_p && $urandom_range(0, 2) != 0) begin
                d_p = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
                d_be = 4'($urandom_range(0, 15));
            end
            if_req = if_p; d_req = d_p;
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rvalid = busy && (cnt == lat);
            mem_rdata = $urandom;
            #1;
            eg_i = !busy && mem_ready && if_p && (!d_p || m_streak == LIMIT);
            eg_d = !busy && mem_ready && d_p && !eg_i;
            n_cmp++;
            if ({if_gnt, d_gnt, mem_req} !== {eg_i, eg_d, eg_i | eg_d}) begin
                n_err++;
                $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc,
                         {if_gnt, d_gnt, mem_req}, {eg_i, eg_d, eg_i | eg_d});
            end
            n_cmp++;
            if ({if_rvalid, d_rvalid} !==
                {busy && mem_rvalid && own_f, busy && mem_rvalid && !own_f}) begin
                n_err++;
                $display("FAIL rnd_rv[%0d]: got %b%b want %b%b", cyc,
                         if_rvalid, d_rvalid, busy && mem_rvalid && own_f,
                         busy && mem_rvalid && !own_f);
            end
            if (busy && mem_rvalid) begin
                n_cmp++;
                if ((own_f ? if_rdata : d_rdata) !== mem_rdata) begin
                    n_err++;
                    $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc,
                             own_f ? if_rdata : d_rdata, mem_rdata);
                end
            end
            if (eg_i || eg_d) begin
                exp_a  = eg_i ? if_addr : d_addr;
                exp_be = (eg_i || !d_we) ? 4'hF : d_be;
                n_cmp++;
                if (mem_addr !== exp_a || mem_be !== exp_be
                    || mem_we !== (eg_d && d_we)) begin
                    n_err++;
                    $display("FAIL rnd_bus[%0d]: got %h %h %b want %h %h %b", cyc,
                             mem_addr, mem_be, mem_we, exp_a, exp_be, eg_d && d_we);
                end
            end
            if (eg_d && if_p) begin
                wait_d++;
                n_cmp++;
                if (wait_d > LIMIT) begin
                    n_err++;
                    $display("FAIL rnd_starve[%0d]: got %0d want <= %0d",
                             cyc, wait_d, LIMIT);
                end
            end
            if (eg_i) begin
                busy = 1; own_f = 1; if_p = 0; wait_d = 0; m_streak = 0;
                lat = $urandom_range(1, 4); cnt = 1;
            end else if (eg_d) begin
                busy = 1; own_f = 0; d_p = 0;
                if (if_p && m_streak < LIMIT) m_streak++;
                lat = $urandom_range(1, 4); cnt = 1;
            end else if (busy) begin
                if (mem_rvalid) begin
                    busy = 0; txn++;
                end else begin
                    cnt++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (txn < 1000) begin
            n_err++;
            $display("FAIL rnd_budget: got %0d txns want 1000", txn);
        end
        if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
